// File: rtl/pwm_update_scheduler.sv
// Frame-synchronous duty update scheduler: posts land in a shadow store and are flushed to the
// PWM array over APB, one write per dirty channel, on each frame tick. Option: PWM_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module pwm_update_scheduler #(
   parameter int NUM_CH       = 32,
   parameter int CH_BITS      = 5,
   parameter int ADDR_WIDTH   = 15,
   parameter int DUTY_REG_IDX = 2,
   parameter int TIMEOUT_CYC  = 15
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  upd_valid_i,
   input  logic [CH_BITS-1:0]    upd_ch_i,
   input  logic [31:0]           upd_duty_i,
   input  logic                  frame_tick_i,
   input  logic                  err_clr_i,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [31:0]           pwdata_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [CH_BITS-1:0]    err_ch_o,
   output logic                  overrun_o
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SETUP, S_ACCESS} state_e;

   localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);
   localparam logic [2:0]         REG_IDX = 3'(DUTY_REG_IDX);

   state_e                  state_q, state_d;
   logic [CH_BITS-1:0]      idx_q, idx_d;
   logic [NUM_CH-1:0]       dirty_q, dirty_d;
   logic [31:0]             shadow_q [NUM_CH];
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [31:0]             pwdata_q, pwdata_d;
   logic                    err_q, err_d;
   logic [CH_BITS-1:0]      err_ch_q, err_ch_d;
   logic                    overrun_q, overrun_d;
   logic                    upd_ok;
   logic                    tmo_hit;

   assign upd_ok = upd_valid_i && (32'(upd_ch_i) < 32'(NUM_CH));

`ifdef PWM_SCHED_TIMEOUT_EN
   localparam int TMO_BITS = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_BITS-1:0] tmo_cnt_q, tmo_cnt_d;

   // Fires on the last permitted ACCESS cycle; a pready_i in that same cycle still wins.
   assign tmo_hit   = (state_q == S_ACCESS) && !pready_i && (tmo_cnt_q == TMO_BITS'(TIMEOUT_CYC - 1));
   assign tmo_cnt_d = (state_q == S_ACCESS) ? tmo_cnt_q + 1'b1 : '0;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) tmo_cnt_q <= '0;
      else           tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      idx_d     = idx_q;
      dirty_d   = dirty_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      err_d     = err_q;
      err_ch_d  = err_ch_q;
      overrun_d = overrun_q;
      psel_o    = 1'b0;
      penable_o = 1'b0;
      busy_o    = 1'b1;

      if (err_clr_i) begin
         err_d     = 1'b0;
         overrun_d = 1'b0;
      end
      if (frame_tick_i && state_q != S_IDLE) overrun_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (frame_tick_i) begin
               idx_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (dirty_q[idx_q]) begin
               pwdata_d       = shadow_q[idx_q];
               paddr_d        = ADDR_WIDTH'({idx_q, REG_IDX, 2'b00});
               dirty_d[idx_q] = 1'b0;
               state_d        = S_SETUP;
            end else if (idx_q == LAST_CH) begin
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_SETUP: begin
            psel_o  = 1'b1;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (pready_i || tmo_hit) begin
               if (tmo_hit || pslverr_i) begin
                  err_d    = 1'b1;
                  err_ch_d = idx_q;
               end
               if (tmo_hit) dirty_d[idx_q] = 1'b1;
               if (idx_q == LAST_CH) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SCAN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Applied last so a post colliding with the SCAN latch keeps the channel dirty.
      if (upd_ok) dirty_d[upd_ch_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      if (!resetn_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         dirty_q   <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         err_q     <= 1'b0;
         err_ch_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dirty_q   <= dirty_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         err_q     <= err_d;
         err_ch_q  <= err_ch_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      // NOTE: the shadow store is a register file, not RAM, so it can and must reset to zero.
      if (!resetn_i) begin
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      end else if (upd_ok) begin
         shadow_q[upd_ch_i] <= upd_duty_i;
      end
   end

   assign pwrite_o  = psel_o;
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;
   assign err_o     = err_q;
   assign err_ch_o  = err_ch_q;
   assign overrun_o = overrun_q;

endmodule
